// File: rtl/uart_fifo_bridge.sv
// Purpose: buffer host<->UART traffic: a TX FIFO feeds a launch FSM into the UART, and an RX FIFO catches received bytes.
// Latency: a TX byte reaches uart_tx_byte/uart_transmit 1 cycle after the FSM decides to launch; RX bytes are readable 1 cycle after uart_received.
// Backpressure: host writes into a full TX FIFO are dropped silently; a byte received into a full RX FIFO is dropped and sets rx_overrun.
module uart_fifo_bridge #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  // host TX side
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              tx_full,
  output logic [ADDR_W:0]   tx_count,
  // host RX side
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              rx_empty,
  output logic [ADDR_W:0]   rx_count,
  // status
  output logic              rx_overrun,
  input  logic              clr_status,
  output logic [ERR_W-1:0]  rx_err_count,
  output logic              tx_busy,
  // UART core side
  output logic              uart_transmit,
  output logic [7:0]        uart_tx_byte,
  input  logic              uart_is_transmitting,
  input  logic              uart_received,
  input  logic [7:0]        uart_rx_byte,
  input  logic              uart_recv_error
);

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ERR_W-1:0]  ERR_ONE  = ERR_W'(1);
  localparam logic [ERR_W-1:0]  ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    L_IDLE      = 2'd0,
    L_WAIT_BUSY = 2'd1,
    L_WAIT_DONE = 2'd2
  } lstate_t;

  // ------------------------------------------------------------------
  // TX FIFO storage and pointers
  // ------------------------------------------------------------------
  logic [7:0]        tx_mem_q [DEPTH];
  logic [ADDR_W-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
  logic [ADDR_W-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
  logic [ADDR_W:0]   tx_cnt_q, tx_cnt_d;
  logic              tx_push;
  logic              tx_pop;
  logic              tx_nonempty;
  logic [7:0]        tx_head;

  // ------------------------------------------------------------------
  // Launch FSM and registered UART request
  // ------------------------------------------------------------------
  lstate_t           state_q, state_d;
  logic              launch;
  logic              xmit_q, xmit_d;
  logic [7:0]        tx_byte_q, tx_byte_d;

  // ------------------------------------------------------------------
  // RX FIFO storage, pointers and status
  // ------------------------------------------------------------------
  logic [7:0]        rx_mem_q [DEPTH];
  logic [ADDR_W-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
  logic [ADDR_W-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
  logic [ADDR_W:0]   rx_cnt_q, rx_cnt_d;
  logic              rx_full;
  logic              rx_push;
  logic              rx_pop;
  logic              ovr_evt;
  logic              ovr_q, ovr_d;
  logic [ERR_W-1:0]  err_q, err_d;

  // TX push is gated by occupancy; only the launch FSM pops
  assign tx_full     = (tx_cnt_q == CNT_FULL);
  assign tx_nonempty = (tx_cnt_q != '0);
  assign tx_push     = wr_en && !tx_full;
  assign tx_pop      = launch;
  assign tx_head     = tx_mem_q[tx_rd_ptr_q];

  // TX pointer and count next-state; simultaneous push and pop leaves count unchanged
  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_cnt_d    = tx_cnt_q;
    if (tx_push) begin
      tx_wr_ptr_d = tx_wr_ptr_q + PTR_ONE;
    end
    if (tx_pop) begin
      tx_rd_ptr_d = tx_rd_ptr_q + PTR_ONE;
    end
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + CNT_ONE;
      2'b01:   tx_cnt_d = tx_cnt_q - CNT_ONE;
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  // TX storage is written on push only; contents survive reset by design
  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem_q[tx_wr_ptr_q] <= wr_data;
    end
  end

  // TX pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
    end
  end

  // Launch FSM: one request per UART busy cycle, never back-to-back
  always_comb begin
    state_d   = state_q;
    launch    = 1'b0;
    case (state_q)
      L_IDLE: begin
        if (tx_nonempty && !uart_is_transmitting) begin
          launch  = 1'b1;
          state_d = L_WAIT_BUSY;
        end
      end
      L_WAIT_BUSY: begin
        // the UART raises busy the cycle after it sees the request
        if (uart_is_transmitting) begin
          state_d = L_WAIT_DONE;
        end
      end
      L_WAIT_DONE: begin
        if (!uart_is_transmitting) begin
          state_d = L_IDLE;
        end
      end
      default: begin
        state_d = L_IDLE;
      end
    endcase
    xmit_d    = launch;
    tx_byte_d = launch ? tx_head : tx_byte_q;
  end

  // FSM state and the registered request/byte presented to the UART
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= L_IDLE;
      xmit_q    <= 1'b0;
      tx_byte_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      xmit_q    <= xmit_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  assign uart_transmit = xmit_q;
  assign uart_tx_byte  = tx_byte_q;
  assign tx_count      = tx_cnt_q;
  assign tx_busy       = (state_q != L_IDLE) || tx_nonempty;

  // RX push is allowed when full only if the host pops in the same cycle
  assign rx_full  = (rx_cnt_q == CNT_FULL);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_pop   = rd_en && !rx_empty;
  assign rx_push  = uart_received && (!rx_full || rd_en);
  assign ovr_evt  = uart_received && rx_full && !rd_en;

  // RX pointer and count next-state
  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_cnt_d    = rx_cnt_q;
    if (rx_push) begin
      rx_wr_ptr_d = rx_wr_ptr_q + PTR_ONE;
    end
    if (rx_pop) begin
      rx_rd_ptr_d = rx_rd_ptr_q + PTR_ONE;
    end
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + CNT_ONE;
      2'b01:   rx_cnt_d = rx_cnt_q - CNT_ONE;
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  // RX storage is written on push only
  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem_q[rx_wr_ptr_q] <= uart_rx_byte;
    end
  end

  // RX pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
    end else begin
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
    end
  end

  // Status next-state: a new event outranks a coincident clear
  always_comb begin
    ovr_d = ovr_q;
    err_d = err_q;
    if (ovr_evt) begin
      ovr_d = 1'b1;
    end else if (clr_status) begin
      ovr_d = 1'b0;
    end
    if (uart_recv_error) begin
      if (clr_status) begin
        err_d = ERR_ONE;
      end else if (err_q != ERR_MAX) begin
        err_d = err_q + ERR_ONE;
      end
    end else if (clr_status) begin
      err_d = '0;
    end
  end

  // Sticky overrun flag and saturating error counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_q <= 1'b0;
      err_q <= '0;
    end else begin
      ovr_q <= ovr_d;
      err_q <= err_d;
    end
  end

  // first-word fall-through head; stale when empty
  assign rd_data      = rx_mem_q[rx_rd_ptr_q];
  assign rx_count     = rx_cnt_q;
  assign rx_overrun   = ovr_q;
  assign rx_err_count = err_q;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Bench for uart_fifo_bridge: directed stimulus with queued expectations.
// A UART model answers each transmit request with 40 busy cycles.
// A negedge monitor pops the queues whenever the DUT transmits or the host pops RX.
module tb_uart_fifo_bridge;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx_full;
  logic [4:0] tx_count;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rx_empty;
  logic [4:0] rx_count;
  logic       rx_overrun;
  logic       clr_status;
  logic [7:0] rx_err_count;
  logic       tx_busy;
  logic       uart_transmit;
  logic [7:0] uart_tx_byte;
  logic       uart_is_transmitting;
  logic       uart_received;
  logic [7:0] uart_rx_byte;
  logic       uart_recv_error;

  logic       hold_busy;
  logic       model_busy;

  int         n_cmp;
  int         n_err;
  int         cyc;
  int         tx_seen;
  int         last_tx;
  bit         have_last;
  bit         prev_tx;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_model[$];

  uart_fifo_bridge #(.DEPTH(16), .ADDR_W(4), .ERR_W(8)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .wr_en                (wr_en),
    .wr_data              (wr_data),
    .tx_full              (tx_full),
    .tx_count             (tx_count),
    .rd_en                (rd_en),
    .rd_data              (rd_data),
    .rx_empty             (rx_empty),
    .rx_count             (rx_count),
    .rx_overrun           (rx_overrun),
    .clr_status           (clr_status),
    .rx_err_count         (rx_err_count),
    .tx_busy              (tx_busy),
    .uart_transmit        (uart_transmit),
    .uart_tx_byte         (uart_tx_byte),
    .uart_is_transmitting (uart_is_transmitting),
    .uart_received        (uart_received),
    .uart_rx_byte         (uart_rx_byte),
    .uart_recv_error      (uart_recv_error)
  );

  assign uart_is_transmitting = hold_busy | model_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // UART model: busy goes high the cycle after a request and stays high 40 cycles
  initial begin : uart_model
    int  left;
    bit  pend;
    model_busy = 1'b0;
    left = 0;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (left > 0) begin
        left--;
        if (left == 0) model_busy = 1'b0;
      end
      if (pend) begin
        model_busy = 1'b1;
        left = 40;
        pend = 1'b0;
      end
      if (uart_transmit) pend = 1'b1;
    end
  end

  // Monitor: scores every transmit pulse and every RX pop against the queues
  initial begin : monitor
    cyc = 0;
    tx_seen = 0;
    last_tx = 0;
    have_last = 1'b0;
    prev_tx = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (uart_transmit) begin
        chk("tx_pulse_single", {31'd0, prev_tx}, 32'd0);
        chk("tx_expected_pending", {31'd0, tx_exp.size() != 0}, 32'd1);
        if (tx_exp.size() != 0) chk("tx_byte", {24'd0, uart_tx_byte}, {24'd0, tx_exp.pop_front()});
        if (have_last) chk("tx_gap_ge41", {31'd0, (cyc - last_tx) >= 41}, 32'd1);
        have_last = 1'b1;
        last_tx = cyc;
        tx_seen++;
      end
      prev_tx = uart_transmit;
      if (rd_en && !rx_empty) begin
        chk("rx_expected_pending", {31'd0, rx_model.size() != 0}, 32'd1);
        if (rx_model.size() != 0) chk("rd_data", {24'd0, rd_data}, {24'd0, rx_model.pop_front()});
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d transmits", tx_seen);
    $fatal(1, "watchdog");
  end

  // All stimulus tasks start and end 1 time unit after a rising edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b, input bit expect_out);
    wr_en = 1'b1;
    wr_data = b;
    if (expect_out) tx_exp.push_back(b);
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic recv(input logic [7:0] b, input logic rd, input logic clr);
    uart_received = 1'b1;
    uart_rx_byte = b;
    rd_en = rd;
    clr_status = clr;
    if (rx_model.size() < 16 || rd) rx_model.push_back(b);
    step(1);
    uart_received = 1'b0;
    rd_en = 1'b0;
    clr_status = 1'b0;
  endtask

  task automatic read1();
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
  endtask

  task automatic wait_tx(input int target, input int budget);
    for (int i = 0; i < budget && tx_seen < target; i++) step(1);
    chk("wait_tx_count", tx_seen, target);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && (tx_busy || model_busy); i++) step(1);
    chk("wait_idle_tx_busy", {31'd0, tx_busy}, 32'd0);
  endtask

  initial begin : stim
    int base;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    wr_en = 1'b0;
    wr_data = 8'h00;
    rd_en = 1'b0;
    clr_status = 1'b0;
    uart_received = 1'b0;
    uart_rx_byte = 8'h00;
    uart_recv_error = 1'b0;
    hold_busy = 1'b0;
    step(3);

    // reset state
    chk("rst_tx_count", tx_count, 0);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_rx_empty", rx_empty, 1);
    chk("rst_rx_count", rx_count, 0);
    chk("rst_overrun", rx_overrun, 0);
    chk("rst_err", rx_err_count, 0);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_transmit", uart_transmit, 0);
    chk("rst_tx_byte", uart_tx_byte, 0);
    rst = 1'b0;
    step(2);

    // 1: two bytes through the launch FSM
    hold_busy = 1'b1;
    push(8'h55, 1'b1);
    push(8'hA3, 1'b1);
    chk("t1_count2", tx_count, 2);
    chk("t1_busy_queued", tx_busy, 1);
    hold_busy = 1'b0;
    wait_tx(1, 20);
    chk("t1_count1", tx_count, 1);
    wait_tx(2, 200);
    chk("t1_count0", tx_count, 0);
    wait_idle(200);

    // 2: overfill TX while the UART is busy, then drain in order
    hold_busy = 1'b1;
    for (int i = 0; i < 17; i++) push(8'(i), i < 16);
    chk("t2_full", tx_full, 1);
    chk("t2_count16", tx_count, 16);
    chk("t2_no_launch", tx_seen, 2);
    hold_busy = 1'b0;
    wait_tx(18, 16 * 50 + 100);
    wait_idle(200);
    chk("t2_drained", tx_exp.size(), 0);

    // 3: RX basic fill and drain
    recv(8'h11, 1'b0, 1'b0);
    recv(8'h22, 1'b0, 1'b0);
    recv(8'h33, 1'b0, 1'b0);
    chk("t3_count3", rx_count, 3);
    chk("t3_head", rd_data, 8'h11);
    read1();
    chk("t3_head2", rd_data, 8'h22);
    read1();
    read1();
    chk("t3_empty", rx_empty, 1);
    read1();
    chk("t3_count0", rx_count, 0);

    // 4: overrun, clear interplay, full + simultaneous pop
    for (int i = 0; i < 16; i++) recv(8'hB0 + 8'(i), 1'b0, 1'b0);
    chk("t4_count16", rx_count, 16);
    chk("t4_no_ovr", rx_overrun, 0);
    recv(8'hEE, 1'b0, 1'b0);
    chk("t4_ovr", rx_overrun, 1);
    chk("t4_count_after_drop", rx_count, 16);
    clr_status = 1'b1;
    step(1);
    clr_status = 1'b0;
    chk("t4_ovr_cleared", rx_overrun, 0);
    recv(8'hEF, 1'b0, 1'b1);
    chk("t4_ovr_beats_clr", rx_overrun, 1);
    recv(8'hF1, 1'b1, 1'b0);
    chk("t4_count_push_pop", rx_count, 16);
    chk("t4_ovr_sticky", rx_overrun, 1);
    chk("t4_head_b1", rd_data, 8'hB1);
    for (int i = 0; i < 16; i++) read1();
    chk("t4_drained", rx_empty, 1);
    chk("t4_model_drained", rx_model.size(), 0);

    // 5: saturating error counter and clear collision
    uart_recv_error = 1'b1;
    step(300);
    uart_recv_error = 1'b0;
    chk("t5_sat", rx_err_count, 255);
    uart_recv_error = 1'b1;
    clr_status = 1'b1;
    step(1);
    uart_recv_error = 1'b0;
    clr_status = 1'b0;
    chk("t5_err_beats_clr", rx_err_count, 1);
    clr_status = 1'b1;
    step(1);
    clr_status = 1'b0;
    chk("t5_clr", rx_err_count, 0);
    chk("t5_clr_ovr", rx_overrun, 0);

    // 6: asynchronous reset while waiting for the UART to finish
    base = tx_seen;
    recv(8'h99, 1'b0, 1'b0);
    push(8'h61, 1'b1);
    for (int i = 0; i < 5; i++) push(8'h62 + 8'(i), 1'b0);
    step(10);
    chk("t6_launched", tx_seen, base + 1);
    chk("t6_queued5", tx_count, 5);
    chk("t6_rx_nonempty", rx_empty, 0);
    chk("t6_uart_busy", uart_is_transmitting, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_count", tx_count, 0);
    chk("t6_async_transmit", uart_transmit, 0);
    chk("t6_async_rx_empty", rx_empty, 1);
    chk("t6_async_tx_busy", tx_busy, 0);
    rx_model.delete();
    step(2);
    rst = 1'b0;
    step(100);
    chk("t6_no_spurious_tx", tx_seen, base + 1);
    push(8'h77, 1'b1);
    wait_tx(base + 2, 100);
    wait_idle(200);
    chk("t6_tx_exp_empty", tx_exp.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
